// File: rtl/lsu_store_merge.sv
// lsu_store_merge: multicycle load/store sequencer with read-modify-write for
// sub-word stores (SH/SB) and low-lane extraction for sub-word loads (LH/LB).
// Optional build macro: LSU_SIGN_EXT_EN -- LH/LB sign-extend instead of zero-extend.
module lsu_store_merge #(
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] b_in,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_wr,
   output logic [31:0] load_data,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int unsigned CW = 3;

`ifdef LSU_SIGN_EXT_EN
   localparam logic SIGN_EXT = 1'b1;
`else
   localparam logic SIGN_EXT = 1'b0;
`endif

   localparam logic [2:0] OP_LW = 3'b000;
   localparam logic [2:0] OP_LH = 3'b001;
   localparam logic [2:0] OP_LB = 3'b010;
   localparam logic [2:0] OP_SW = 3'b100;
   localparam logic [2:0] OP_SH = 3'b101;
   localparam logic [2:0] OP_SB = 3'b110;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t        state;
   logic [2:0]    op_q;
   logic [15:0]   b_lo;
   logic [CW-1:0] cnt;

   // Only the six defined opcodes start a memory access.
   function automatic logic op_legal(input logic [2:0] o);
      case (o)
         OP_LW, OP_LH, OP_LB, OP_SW, OP_SH, OP_SB: op_legal = 1'b1;
         default:                                  op_legal = 1'b0;
      endcase
   endfunction

   // Merge the low lane of the store source into the fetched word.
   function automatic logic [31:0] merge(input logic [2:0] o, input logic [31:0] w,
                                         input logic [15:0] b);
      case (o)
         OP_SH:   merge = {w[31:16], b};
         default: merge = {w[31:8], b[7:0]};
      endcase
   endfunction

   // Extract the low lane of the fetched word for a load.
   function automatic logic [31:0] extend(input logic [2:0] o, input logic [31:0] w);
      case (o)
         OP_LH:   extend = {{16{SIGN_EXT & w[15]}}, w[15:0]};
         OP_LB:   extend = {{24{SIGN_EXT & w[7]}}, w[7:0]};
         default: extend = w;
      endcase
   endfunction

   // Sequencer: state and all outputs registered together. The fetched word is
   // consumed on the same edge that captures it, so no separate word register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         op_q      <= 3'b000;
         b_lo      <= 16'h0000;
         cnt       <= '0;
         mem_addr  <= 32'h0000_0000;
         mem_wdata <= 32'h0000_0000;
         mem_wr    <= 1'b0;
         load_data <= 32'h0000_0000;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_q     <= op;
                  b_lo     <= b_in[15:0];
                  mem_addr <= addr;
                  busy     <= 1'b1;
                  if (!op_legal(op)) begin
                     done  <= 1'b1;
                     err   <= 1'b1;
                     state <= DONE;
                  end else if (op == OP_SW) begin
                     mem_wdata <= b_in;
                     mem_wr    <= 1'b1;
                     state     <= WRITE;
                  end else begin
                     cnt   <= CW'(MEM_LATENCY);
                     state <= READ;
                  end
               end
            end
            READ: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  if (op_q[2]) begin
                     mem_wdata <= merge(op_q, mem_rdata, b_lo);
                     mem_wr    <= 1'b1;
                     state     <= WRITE;
                  end else begin
                     load_data <= extend(op_q, mem_rdata);
                     done      <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            WRITE: begin
               mem_wr <= 1'b0;
               done   <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               err   <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_store_merge.sv
// Bench for lsu_store_merge: word memory with configurable read latency,
// directed merge/extension/reset cases and randomized transactions checked
// against a transaction-level reference model. Honors LSU_SIGN_EXT_EN.
module tb_lsu_store_merge #(
   parameter int unsigned LAT = 1
);

`ifdef LSU_SIGN_EXT_EN
   localparam bit SIGN = 1'b1;
`else
   localparam bit SIGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] addr;
   logic [31:0] b_in;
   logic [31:0] mem_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_wr;
   logic [31:0] load_data;
   logic        busy;
   logic        done;
   logic        err;

   int n_checks = 0;
   int n_pass   = 0;

   lsu_store_merge #(.MEM_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .b_in(b_in),
      .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wr(mem_wr), .load_data(load_data), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Memory: 16 words indexed by the low address bits, read data delayed LAT-1 cycles.
   logic [31:0] mem [0:15];
   logic [31:0] apipe [0:7];
   localparam int unsigned PIDX = (LAT >= 2) ? LAT - 2 : 0;

   always @(posedge clk) begin
      if (mem_wr) mem[mem_addr[3:0]] <= mem_wdata;
      apipe[0] <= mem_addr;
      for (int i = 1; i < 8; i++) apipe[i] <= apipe[i-1];
   end

   always_comb begin
      mem_rdata = (LAT <= 1) ? mem[mem_addr[3:0]] : mem[apipe[PIDX][3:0]];
   end

   // Reference state: memory image and last completed load value.
   logic [31:0] ref_mem [0:15];
   logic [31:0] exp_ld = 32'h0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] ext_ref(input logic [31:0] w, input int bits);
      logic [31:0] m;
      logic [31:0] v;
      m = (bits == 16) ? 32'h0000_FFFF : 32'h0000_00FF;
      v = w & m;
      if (SIGN && w[bits-1]) v = v | ~m;
      return v;
   endfunction

   // One transaction: expected timing and data come from the op's rules.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit junk);
      int          idx;
      bit          legal, is_store, is_load;
      int          exp_done, exp_wr_cyc;
      logic [31:0] exp_wd, w;
      int          dcnt, dcyc, wcnt, wcyc;
      logic [31:0] got_wd, got_ld, got_ma;
      logic        got_err, busy1, busy_d;

      idx      = int'(a[3:0]);
      w        = ref_mem[idx];
      legal    = (o != 3'b011) && (o != 3'b111);
      is_store = legal && o[2];
      is_load  = legal && !o[2];
      exp_wd   = 32'h0;
      exp_wr_cyc = 0;
      if (!legal)            exp_done = 1;
      else if (o == 3'b100)  begin exp_done = 2; exp_wr_cyc = 1; exp_wd = b; end
      else if (is_store)     begin
         exp_done   = LAT + 2;
         exp_wr_cyc = LAT + 1;
         exp_wd = (o == 3'b101) ? ((w & 32'hFFFF_0000) | (b & 32'h0000_FFFF))
                                : ((w & 32'hFFFF_FF00) | (b & 32'h0000_00FF));
      end else exp_done = LAT + 1;
      if (is_load) begin
         if (o == 3'b000)      exp_ld = w;
         else if (o == 3'b001) exp_ld = ext_ref(w, 16);
         else                  exp_ld = ext_ref(w, 8);
      end

      @(negedge clk);
      start = 1'b1; op = o; addr = a; b_in = b;
      dcnt = 0; dcyc = 0; wcnt = 0; wcyc = 0;
      got_wd = 32'h0; got_ld = 32'h0; got_ma = 32'h0; got_err = 1'b0;
      busy1 = 1'b0; busy_d = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) busy1 = busy;
         if (done) begin
            dcnt++; dcyc = c; got_ld = load_data; got_err = err; got_ma = mem_addr;
            busy_d = busy;
         end
         if (mem_wr) begin wcnt++; wcyc = c; got_wd = mem_wdata; end
         op = 3'($urandom); addr = $urandom; b_in = $urandom;
         start = (junk && c <= exp_done) ? 1'($urandom) : 1'b0;
      end
      start = 1'b0;

      check("done_count", 32'(dcnt), 32'd1);
      check("done_cycle", 32'(dcyc), 32'(exp_done));
      check("err", {31'h0, got_err}, {31'h0, !legal});
      check("busy_c1", {31'h0, busy1}, 32'd1);
      check("busy_done", {31'h0, busy_d}, 32'd1);
      check("busy_idle", {31'h0, busy}, 32'd0);
      check("mem_addr", got_ma, a);
      check("wr_count", 32'(wcnt), (exp_wr_cyc != 0) ? 32'd1 : 32'd0);
      if (exp_wr_cyc != 0) begin
         check("wr_cycle", 32'(wcyc), 32'(exp_wr_cyc));
         check("wdata", got_wd, exp_wd);
         ref_mem[idx] = exp_wd;
      end
      check("load_data", load_data, exp_ld);
      if (is_load) check("load_at_done", got_ld, exp_ld);
   endtask

   initial begin
      logic [31:0] a;
      bit          seen;
      reset = 1'b0; start = 1'b0; op = 3'b000; addr = 32'h0; b_in = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_wdata", mem_wdata, 32'h0);
      check("rst_ld", load_data, 32'h0);
      check("rst_ctl", {28'h0, mem_wr, busy, done, err}, 32'h0);
      reset = 1'b1;

      // Preload every word through SW.
      for (int i = 0; i < 16; i++) run_op(3'b100, 32'(i), $urandom, 1'b0);

      // Directed merges, extension and illegal op.
      run_op(3'b100, 32'h1, 32'h1122_3344, 1'b0);
      run_op(3'b110, 32'h1, 32'hAABB_CCDD, 1'b0);
      check("sb_image", ref_mem[1], 32'h1122_33DD);
      run_op(3'b100, 32'h1, 32'h1122_3344, 1'b0);
      run_op(3'b101, 32'h1, 32'hAABB_CCDD, 1'b0);
      check("sh_image", ref_mem[1], 32'h1122_CCDD);
      run_op(3'b100, 32'h2, 32'hDEAD_BEEF, 1'b0);
      run_op(3'b100, 32'h3, 32'h0000_00F0, 1'b0);
      run_op(3'b010, 32'h3, 32'h0, 1'b0);
      check("lb_value", load_data, SIGN ? 32'hFFFF_FFF0 : 32'h0000_00F0);
      run_op(3'b011, 32'h4, 32'h1234_5678, 1'b1);
      run_op(3'b000, 32'h2, 32'h0, 1'b1);
      run_op(3'b001, 32'h1, 32'h0, 1'b1);

      // Reset during the WRITE cycle of an SH: no strobe, all outputs cleared.
      a = 32'h5;
      @(negedge clk);
      start = 1'b1; op = 3'b101; addr = a; b_in = 32'h5A5A_5A5A;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 12 && !seen; c++) begin
         if (mem_wr) seen = 1'b1;
         else @(negedge clk);
      end
      check("rst_wr_seen", {31'h0, seen}, 32'd1);
      #1 reset = 1'b0;
      #1;
      check("rst_mid_wr", {31'h0, mem_wr}, 32'd0);
      check("rst_mid_ctl", {29'h0, busy, done, err}, 32'd0);
      check("rst_mid_addr", mem_addr, 32'h0);
      check("rst_mid_wd", mem_wdata, 32'h0);
      check("rst_mid_ld", load_data, 32'h0);
      exp_ld = 32'h0;
      @(negedge clk);
      reset = 1'b1;
      run_op(3'b000, a, 32'h0, 1'b0);
      check("rst_no_write", load_data, ref_mem[5]);

      // Randomized transactions with stray start pulses while busy.
      for (int n = 0; n < 60; n++)
         run_op(3'($urandom), $urandom, $urandom, 1'($urandom));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
